// File: rtl/vector_loader.sv
`default_nettype none
// ============================================================================
// Module      : vector_loader
// Description : Assembles (a, b) element pairs from a valid/ready stream into
//               WEIGHT_SIZE-element operand vectors for vector_mult. Two
//               ping-pong banks let the next vector load while the current one
//               is held for the consumer. Short vectors close on in_last_i and
//               their unused lanes read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int WEIGHT_SIZE = 9,
    parameter int LEN_W       = $clog2(WEIGHT_SIZE + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_a_i,
    input  logic [DATA_WIDTH-1:0] in_b_i,
    input  logic                  in_last_i,
    output logic                  vec_valid_o,
    input  logic                  vec_ready_i,
    output logic [DATA_WIDTH-1:0] vec_a_o [WEIGHT_SIZE],
    output logic [DATA_WIDTH-1:0] vec_b_o [WEIGHT_SIZE],
    output logic [LEN_W-1:0]      vec_len_o
);

    // Element index width; a single-element vector still needs one bit.
    localparam int c_cnt_w = (WEIGHT_SIZE > 1) ? $clog2(WEIGHT_SIZE) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WEIGHT_SIZE - 1);

    // Bank storage: data is not reset, validity is carried by r_full/r_len.
    logic [DATA_WIDTH-1:0] r_bank_a [2][WEIGHT_SIZE];
    logic [DATA_WIDTH-1:0] r_bank_b [2][WEIGHT_SIZE];
    logic [LEN_W-1:0]      r_len    [2];
    logic [1:0]            r_full;
    logic                  r_wb;
    logic                  r_rb;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_in_fire;
    logic                  w_close;
    logic                  w_free;
    logic [1:0]            w_full_nxt;
    logic [LEN_W-1:0]      w_rd_len;

    // Ready depends only on registered state, never on vec_ready_i.
    assign in_ready_o  = ~r_full[r_wb];
    assign vec_valid_o = r_full[r_rb];
    assign w_in_fire   = in_valid_i & in_ready_o;
    assign w_close     = w_in_fire & (in_last_i | (r_cnt == c_last_idx));
    assign w_free      = vec_valid_o & vec_ready_i;
    assign w_rd_len    = r_len[r_rb];

    // Next full flags; closing and freeing always target different banks
    // because a full write bank blocks input, so both can apply together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_free) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        if (w_close) begin
            w_full_nxt[r_wb] = 1'b1;
        end
    end

    // Control state: bank pointers, element index, lengths and full flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_full   <= 2'b00;
            r_wb     <= 1'b0;
            r_rb     <= 1'b0;
            r_cnt    <= '0;
            r_len[0] <= '0;
            r_len[1] <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_fire) begin
                if (w_close) begin
                    r_len[r_wb] <= LEN_W'(r_cnt) + LEN_W'(1);
                    r_wb        <= ~r_wb;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
            if (w_free) begin
                r_rb <= ~r_rb;
            end
        end
    end

    // Element capture into the current write bank.
    always_ff @(posedge clk_i) begin
        if (w_in_fire) begin
            r_bank_a[r_wb][r_cnt] <= in_a_i;
            r_bank_b[r_wb][r_cnt] <= in_b_i;
        end
    end

    // Read-bank presentation; lanes past the length (or with no vector
    // pending) read as zero so stale data never reaches the multiplier.
    always_comb begin
        vec_len_o = vec_valid_o ? w_rd_len : '0;
        for (int i = 0; i < WEIGHT_SIZE; i++) begin
            vec_a_o[i] = '0;
            vec_b_o[i] = '0;
            if (vec_valid_o && (i < int'(w_rd_len))) begin
                vec_a_o[i] = r_bank_a[r_rb][i];
                vec_b_o[i] = r_bank_b[r_rb][i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_loader
// Description : Scoreboard bench for vector_loader. Accepted beats build
//               expected vectors in a queue; a negedge monitor compares the
//               presented vector, ready and valid against that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_loader;

    localparam int DW = 8;
    localparam int WS = 9;
    localparam int LW = $clog2(WS + 1);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          vec_ready = 1'b0;
    logic [DW-1:0] in_a      = '0;
    logic [DW-1:0] in_b      = '0;
    logic          in_ready;
    logic          vec_valid;
    logic [DW-1:0] vec_a [WS];
    logic [DW-1:0] vec_b [WS];
    logic [LW-1:0] vec_len;

    vector_loader #(
        .DATA_WIDTH  (DW),
        .WEIGHT_SIZE (WS),
        .LEN_W       (LW)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_last_i   (in_last),
        .vec_valid_o (vec_valid),
        .vec_ready_i (vec_ready),
        .vec_a_o     (vec_a),
        .vec_b_o     (vec_b),
        .vec_len_o   (vec_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int a [WS];
        int b [WS];
    } vec_t;

    vec_t exp_q  [$];
    int   part_a [$];
    int   part_b [$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   stop_rand = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare the DUT against the model, then apply the handshakes
    // that will fire on the coming rising edge.
    always @(negedge clk) begin
        vec_t e;
        vec_t v;
        int   bad_idx;
        int   psum_dut;
        int   psum_exp;
        if (!rst_n) begin
            bad_idx = -1;
            for (int i = 0; i < WS; i++)
                if (vec_a[i] != '0 || vec_b[i] != '0) bad_idx = i;
            check("rst_valid", int'(vec_valid), 0);
            check("rst_len", int'(vec_len), 0);
            check("rst_data_nonzero_lane", bad_idx, -1);
        end else begin
            check("in_ready", int'(in_ready), (exp_q.size() < 2) ? 1 : 0);
            check("vec_valid", int'(vec_valid), (exp_q.size() > 0) ? 1 : 0);
            if (vec_valid && exp_q.size() > 0) begin
                e        = exp_q[0];
                bad_idx  = -1;
                psum_dut = 0;
                psum_exp = 0;
                for (int i = 0; i < WS; i++) begin
                    if (int'(vec_a[i]) != e.a[i] || int'(vec_b[i]) != e.b[i])
                        if (bad_idx < 0) bad_idx = i;
                    psum_dut += int'(vec_a[i]) * int'(vec_b[i]);
                end
                for (int i = 0; i < e.len; i++) psum_exp += e.a[i] * e.b[i];
                check("vec_len", int'(vec_len), e.len);
                check("vec_first_bad_lane", bad_idx, -1);
                check("psum", psum_dut, psum_exp);
            end
            if (vec_valid && vec_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                part_a.push_back(int'(in_a));
                part_b.push_back(int'(in_b));
                if (in_last || part_a.size() == WS) begin
                    v.len = part_a.size();
                    for (int i = 0; i < WS; i++) begin
                        v.a[i] = (i < v.len) ? part_a[i] : 0;
                        v.b[i] = (i < v.len) ? part_b[i] : 0;
                    end
                    exp_q.push_back(v);
                    part_a.delete();
                    part_b.delete();
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitc++;
            if (waitc > 1000) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 1000 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [DW-1:0] snap_a0;
        logic [LW-1:0] snap_len;

        // Reset, then a full 1..9 x 2 vector.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        vec_ready = 1'b1;
        for (int i = 1; i <= WS; i++) send(8'(i), 8'd2, 1'b0);
        idle(3);

        // Short vector, four beats.
        for (int i = 0; i < 4; i++) send(8'd3, 8'd5, (i == 3));
        idle(3);

        // Single element vector.
        send(8'd7, 8'd6, 1'b1);
        idle(3);

        // Back-pressure: three vectors with the consumer stalled.
        vec_ready = 1'b0;
        fork
            begin
                for (int v = 0; v < 3; v++)
                    for (int k = 0; k < WS; k++) send(8'(v * 16 + k), 8'(k + 1), 1'b0);
            end
            begin
                repeat (25) @(posedge clk);
                #1;
                check("bp_stalled_ready", int'(in_ready), 0);
                vec_ready = 1'b1;
                @(posedge clk);
                #1;
                vec_ready = 1'b0;
                check("bp_ready_after_free", int'(in_ready), 1);
            end
        join
        idle(2);
        vec_ready = 1'b1;
        idle(5);

        // Hold stability: pending vector held while another one loads.
        vec_ready = 1'b0;
        for (int k = 0; k < WS; k++) send(8'(200 + k), 8'(100 - k), 1'b0);
        snap_a0  = vec_a[0];
        snap_len = vec_len;
        for (int k = 0; k < WS; k++) send(8'(50 + k), 8'(k), 1'b0);
        idle(1);
        check("hold_a0", int'(vec_a[0]), 200);
        check("hold_a0_snapshot", int'(vec_a[0]), int'(snap_a0));
        check("hold_len_snapshot", int'(vec_len), int'(snap_len));
        vec_ready = 1'b1;
        idle(4);

        // Reset mid-load with one full vector stored.
        vec_ready = 1'b0;
        for (int k = 0; k < WS; k++) send(8'(k + 11), 8'(k + 3), 1'b0);
        for (int k = 0; k < 5; k++) send(8'(k + 90), 8'(k + 1), 1'b0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        part_a.delete();
        part_b.delete();
        #1;
        check("async_reset_valid", int'(vec_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        vec_ready = 1'b1;
        for (int k = 0; k < WS; k++) send(8'(k + 1), 8'(k + 1), 1'b0);
        idle(3);

        // Randomized traffic with random back-pressure and stray in_last.
        stop_rand = 1'b0;
        fork
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1;
                    vec_ready = ($urandom_range(0, 2) != 0);
                end
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_last = ($urandom_range(0, 1) == 1);
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                        in_last = 1'b0;
                    end
                    send(8'($urandom), 8'($urandom), (n == 299) || ($urandom_range(0, 4) == 0));
                end
                stop_rand = 1'b1;
            end
        join
        #1;
        vec_ready = 1'b1;
        idle(10);
        check("drained_queue", exp_q.size(), 0);
        check("drained_partial", part_a.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_loader.md
Name: vector_loader

Overview:
- Feeder for the vector_mult datapath.
- Accepts one (a, b) element pair per beat over a valid/ready stream and assembles WEIGHT_SIZE-element operand vectors.
- Presents complete vectors as parallel arrays, matching the vector_mult a/b port shape, under a valid/ready handshake.
- Ping-pong buffered: the next vector loads while the current one is held for the consumer.

Parameters:
DATA_WIDTH, 8, bit width of each a/b element (matches `DATA_WIDTH)
WEIGHT_SIZE, 9, elements per vector (matches `WEIGHT_SIZE; 3x3 kernel)
LEN_W, $clog2(WEIGHT_SIZE+1), width of the vector length field

Ports:
clk_i  input  1  single clock, rising edge
rst_ni  input  1  reset, asynchronous assert, active-low
in_valid_i  input  1  element pair valid
in_ready_o  output  1  loader can accept an element pair
in_a_i  input  DATA_WIDTH  a element
in_b_i  input  DATA_WIDTH  b element
in_last_i  input  1  this beat closes the vector early (short vector)
vec_valid_o  output  1  complete vector available
vec_ready_i  input  1  consumer takes the vector
vec_a_o  output  DATA_WIDTH x [WEIGHT_SIZE]  unpacked array, a operands
vec_b_o  output  DATA_WIDTH x [WEIGHT_SIZE]  unpacked array, b operands
vec_len_o  output  LEN_W  number of valid elements, 1..WEIGHT_SIZE

Behaviour:
- Storage:
  - Two banks (0/1), each WEIGHT_SIZE a/b entries plus a registered len and full flag.
  - Write-bank pointer wb, read-bank pointer rb, element index cnt (0..WEIGHT_SIZE-1).
- Reset (rst_ni low, async):
  - full flags = 0; wb = rb = 0; cnt = 0.
  - vec_valid_o = 0, vec_len_o = 0, vec_a_o/vec_b_o all 0.
  - in_ready_o = 1 after reset release.
  - Reset mid-operation discards partial and stored vectors; no vector is emitted afterwards from pre-reset data.
- Input accept:
  - in_ready_o = !full[wb], driven from registers only; no combinational path from vec_ready_i.
  - A beat fires on in_valid_i & in_ready_o.
  - Element is stored to bank[wb][cnt], then cnt increments.
- Vector close: on a fired beat with cnt == WEIGHT_SIZE-1 or in_last_i = 1:
  - len[wb] = cnt+1; full[wb] = 1; wb toggles; cnt = 0.
- Zero padding: for i >= vec_len_o, vec_a_o[i] and vec_b_o[i] read as 0, so vector_mult psum is unaffected by stale data.
- Output:
  - vec_valid_o = full[rb]; vec_a_o/vec_b_o/vec_len_o come from bank rb.
  - Latency: closing beat at cycle t -> vec_valid_o = 1 at t+1.
  - On vec_valid_o & vec_ready_i: full[rb] = 0; rb toggles.
  - While vec_valid_o = 1 and vec_ready_i = 0, all vector outputs hold stable.
- Simultaneous events: closing bank wb and freeing bank rb in the same cycle are both applied.
- Throughput and back-pressure:
  - Sustained throughput is one vector per WEIGHT_SIZE cycles with vec_ready_i held high.
  - With both banks full, in_ready_o = 0 until one bank frees.
  - in_ready_o returns to 1 the cycle after the freeing handshake.
- Boundary cases:
  - in_last_i on the first element gives len 1.
  - in_last_i on element WEIGHT_SIZE-1 is identical to a normal close.
  - in_last_i without in_valid_i is ignored.
  - cnt never exceeds WEIGHT_SIZE-1.
- Arithmetic: none. Data is passed unmodified; no sign interpretation.

Test Plan:
- Reset and single vector:
  - Stimulus: reset; stream a=1..9, b=2 each cycle, vec_ready_i=1.
  - Required: vec_valid_o rises the cycle after beat 9; vec_a_o={1..9}, vec_b_o all 2, vec_len_o=9; vector_mult psum=90.
- Short vector:
  - Stimulus: 4 beats a=3, b=5, in_last_i on beat 4.
  - Required: vec_len_o=4; entries 4..8 read 0; psum=60.
- Back-pressure:
  - Stimulus: vec_ready_i=0; stream 3 full vectors.
  - Required: in_ready_o drops after beat 18 and the third vector stalls.
  - Then: raise vec_ready_i for 1 cycle; in_ready_o=1 next cycle; vectors emerge in order 1, 2, 3 with no loss or duplication.
- Hold stability:
  - Stimulus: vector pending, vec_ready_i=0 for 10 cycles while a new vector loads.
  - Required: vec_a_o/vec_b_o/vec_len_o unchanged for all 10 cycles.
- Reset mid-load:
  - Stimulus: assert rst_ni low after 5 beats, with one full vector also stored.
  - Required: vec_valid_o=0 immediately (async); after release, a fresh 9-beat vector emits correctly with len 9.
- Single-element vector:
  - Stimulus: in_last_i on the first beat, a=7, b=6.
  - Required: vec_len_o=1, psum=42.
